// File: rtl/xbar_bank_arb.sv
// -----------------------------------------------------------------------------
// xbar_bank_arb
//
// One bank slice of a 3-channel crossbar. Each channel presents a request with
// a line address; a request belongs to this bank when addr[5:4] == BANK_ID.
// Competing requests are arbitrated round-robin, and the winner is loaded into
// a single-entry output register facing the bank HTU. That register is
// refilled in the same cycle it is drained, so back-to-back requests leave no
// bubble.
//
// Each channel keeps a 3-bit ROB tag pointer, which tags every granted request,
// and an outstanding counter in the range 0..8. A channel stops receiving
// grants once it has 8 requests in flight. The channel's rtn_done pulse
// retires one of them.
//
// Ports
//   clk_i                  single clock, rising edge
//   rst_i                  synchronous active-high reset
//   chN_req_valid_i        channel N request valid            (N = 0..2)
//   chN_req_allowIn_o      channel N granted this cycle (combinational)
//   chN_req_op_i           channel N opcode
//   chN_req_addr_i         channel N line address [31:4]
//   chN_rtn_done_i         retires one outstanding channel N request
//   bank_htu_valid_o       output register holds a request
//   bank_htu_allowIn_i     HTU accepts the output register this cycle
//   bank_htu_ch_id_o       source channel of the held request
//   bank_htu_opcode_o      opcode of the held request
//   bank_htu_addr_o        address of the held request
//   bank_htu_rob_num_o     per-channel ROB tag of the held request
// -----------------------------------------------------------------------------
module xbar_bank_arb #(
    parameter logic [1:0] BANK_ID = 2'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ch0_req_valid_i,
    output logic        ch0_req_allowIn_o,
    input  logic [1:0]  ch0_req_op_i,
    input  logic [31:4] ch0_req_addr_i,
    input  logic        ch0_rtn_done_i,

    input  logic        ch1_req_valid_i,
    output logic        ch1_req_allowIn_o,
    input  logic [1:0]  ch1_req_op_i,
    input  logic [31:4] ch1_req_addr_i,
    input  logic        ch1_rtn_done_i,

    input  logic        ch2_req_valid_i,
    output logic        ch2_req_allowIn_o,
    input  logic [1:0]  ch2_req_op_i,
    input  logic [31:4] ch2_req_addr_i,
    input  logic        ch2_rtn_done_i,

    output logic        bank_htu_valid_o,
    input  logic        bank_htu_allowIn_i,
    output logic [1:0]  bank_htu_ch_id_o,
    output logic [1:0]  bank_htu_opcode_o,
    output logic [31:4] bank_htu_addr_o,
    output logic [2:0]  bank_htu_rob_num_o
);

    localparam int NUM_CH = 3;
    localparam logic [3:0] MAX_OUTSTANDING = 4'd8;

    // -------------------------------------------------------------------------
    // Channel inputs gathered into arrays so the per-channel logic below can
    // be generated once.
    // -------------------------------------------------------------------------
    logic        req_valid  [NUM_CH];
    logic [1:0]  req_op     [NUM_CH];
    logic [31:4] req_addr   [NUM_CH];
    logic        rtn_done   [NUM_CH];
    logic        grant_hot  [NUM_CH];

    assign req_valid[0] = ch0_req_valid_i;
    assign req_valid[1] = ch1_req_valid_i;
    assign req_valid[2] = ch2_req_valid_i;

    assign req_op[0]    = ch0_req_op_i;
    assign req_op[1]    = ch1_req_op_i;
    assign req_op[2]    = ch2_req_op_i;

    assign req_addr[0]  = ch0_req_addr_i;
    assign req_addr[1]  = ch1_req_addr_i;
    assign req_addr[2]  = ch2_req_addr_i;

    assign rtn_done[0]  = ch0_rtn_done_i;
    assign rtn_done[1]  = ch1_rtn_done_i;
    assign rtn_done[2]  = ch2_rtn_done_i;

    assign ch0_req_allowIn_o = grant_hot[0];
    assign ch1_req_allowIn_o = grant_hot[1];
    assign ch2_req_allowIn_o = grant_hot[2];

    // -------------------------------------------------------------------------
    // Per-channel state: ROB tag pointer and outstanding counter
    // -------------------------------------------------------------------------
    logic [2:0] rob_ptr_reg     [NUM_CH];
    logic [3:0] outstanding_reg [NUM_CH];
    logic       hit             [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic inc;
            logic dec;

            // A channel at 8 in flight is not eligible, so the counter can
            // never overflow past 8.
            assign hit[gi] = req_valid[gi]
                           && (req_addr[gi][5:4] == BANK_ID)
                           && (outstanding_reg[gi] < MAX_OUTSTANDING);

            assign inc = grant_hot[gi];
            // A retire pulse with nothing outstanding is dropped.
            assign dec = rtn_done[gi] && (outstanding_reg[gi] != 4'd0);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rob_ptr_reg[gi]     <= 3'd0;
                    outstanding_reg[gi] <= 4'd0;
                end else begin
                    if (inc) begin
                        rob_ptr_reg[gi] <= rob_ptr_reg[gi] + 3'd1;  // wraps 7 -> 0
                    end
                    // A grant and a retire in the same cycle cancel out.
                    if (inc && !dec) begin
                        outstanding_reg[gi] <= outstanding_reg[gi] + 4'd1;
                    end else if (dec && !inc) begin
                        outstanding_reg[gi] <= outstanding_reg[gi] - 4'd1;
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbiter
    // -------------------------------------------------------------------------
    logic       out_valid_reg;
    logic [1:0] out_ch_id_reg;
    logic [1:0] out_opcode_reg;
    logic [31:4] out_addr_reg;
    logic [2:0] out_rob_num_reg;

    logic [1:0] last_grant_reg;
    logic       load;
    logic       grant_valid;
    logic [1:0] grant_idx;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // The output register may take a new entry when it is empty or is being
    // drained this cycle.
    assign load = !out_valid_reg || bank_htu_allowIn_i;

    always_comb begin
        logic [1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = next_ch(last_grant_reg);
        // Search starts just after the last winner. Nothing is granted while
        // reset is asserted.
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_valid && !rst_i && load && hit[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
            cand = next_ch(cand);
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign grant_hot[gi] = grant_valid && (grant_idx == gi[1:0]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_reg <= 2'd2;          // channel 0 gets first priority
        end else if (grant_valid) begin
            last_grant_reg <= grant_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Single-entry output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg   <= 1'b0;
            out_ch_id_reg   <= 2'd0;
            out_opcode_reg  <= 2'd0;
            out_addr_reg    <= '0;
            out_rob_num_reg <= 3'd0;
        end else if (grant_valid) begin
            out_valid_reg   <= 1'b1;
            out_ch_id_reg   <= grant_idx;
            out_opcode_reg  <= req_op[grant_idx];
            out_addr_reg    <= req_addr[grant_idx];
            out_rob_num_reg <= rob_ptr_reg[grant_idx];
        end else if (out_valid_reg && bank_htu_allowIn_i) begin
            // Drained with nothing behind it. The fields keep their last
            // values so that only the valid bit changes.
            out_valid_reg   <= 1'b0;
        end
    end

    assign bank_htu_valid_o   = out_valid_reg;
    assign bank_htu_ch_id_o   = out_ch_id_reg;
    assign bank_htu_opcode_o  = out_opcode_reg;
    assign bank_htu_addr_o    = out_addr_reg;
    assign bank_htu_rob_num_o = out_rob_num_reg;

endmodule

// File: tb/tb_xbar_bank_arb.sv
module tb_xbar_bank_arb;

    localparam logic [1:0] BANK = 2'd1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  req_valid;
    logic [1:0]  req_op   [3];
    logic [31:4] req_addr [3];
    logic [2:0]  rtn_done;
    logic        htu_allow;

    logic        ch0_allow, ch1_allow, ch2_allow;
    logic [2:0]  allow_vec;
    logic        htu_valid;
    logic [1:0]  htu_ch_id;
    logic [1:0]  htu_opcode;
    logic [31:4] htu_addr;
    logic [2:0]  htu_rob;

    assign allow_vec = {ch2_allow, ch1_allow, ch0_allow};

    always #5 clk_i = ~clk_i;

    xbar_bank_arb #(.BANK_ID(BANK)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ch0_req_valid_i    (req_valid[0]),
        .ch0_req_allowIn_o  (ch0_allow),
        .ch0_req_op_i       (req_op[0]),
        .ch0_req_addr_i     (req_addr[0]),
        .ch0_rtn_done_i     (rtn_done[0]),
        .ch1_req_valid_i    (req_valid[1]),
        .ch1_req_allowIn_o  (ch1_allow),
        .ch1_req_op_i       (req_op[1]),
        .ch1_req_addr_i     (req_addr[1]),
        .ch1_rtn_done_i     (rtn_done[1]),
        .ch2_req_valid_i    (req_valid[2]),
        .ch2_req_allowIn_o  (ch2_allow),
        .ch2_req_op_i       (req_op[2]),
        .ch2_req_addr_i     (req_addr[2]),
        .ch2_rtn_done_i     (rtn_done[2]),
        .bank_htu_valid_o   (htu_valid),
        .bank_htu_allowIn_i (htu_allow),
        .bank_htu_ch_id_o   (htu_ch_id),
        .bank_htu_opcode_o  (htu_opcode),
        .bank_htu_addr_o    (htu_addr),
        .bank_htu_rob_num_o (htu_rob)
    );

    typedef struct {
        int          ch;
        logic [1:0]  op;
        logic [31:4] addr;
        int          rob;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    // Reference model state
    int m_outst [3];
    int m_rob   [3];
    int m_last;
    bit m_valid;

    typedef struct {
        int       cycles;
        int       p_valid;
        int       p_bank;
        int       p_allow;
        int       p_done;
        int       p_rst;
        bit [2:0] mask;
    } phase_t;

    phase_t phases[8];

    function automatic bit chance(int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: pops the expected entry when the HTU accepts the output.
    always @(negedge clk_i) begin
        #2;
        if (rst_i !== 1'b1 && htu_valid === 1'b1 && htu_allow === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_empty: got ch=%0d rob=%0d, required no output", htu_ch_id, htu_rob);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (htu_ch_id == e.ch[1:0] && htu_opcode == e.op && htu_addr == e.addr
                    && htu_rob == e.rob[2:0]) begin
                    passed++;
                    $display("xfer ch=%0d op=%0d addr=%07h rob=%0d", htu_ch_id, htu_opcode, htu_addr, htu_rob);
                end else begin
                    $display("FAIL xfer: got ch=%0d op=%0d addr=%07h rob=%0d, required ch=%0d op=%0d addr=%07h rob=%0d",
                             htu_ch_id, htu_opcode, htu_addr, htu_rob, e.ch, e.op, e.addr, e.rob);
                end
            end
        end
    end

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_outst[n] = 0;
            m_rob[n]   = 0;
        end
        m_last  = 2;
        m_valid = 0;
        sb.delete();
    endtask

    // One cycle: drive inputs, check grant and valid against the model, update model.
    task automatic run_cycle(phase_t ph, bit no_done);
        int  grant;
        bit  hit [3];
        bit  load;
        @(negedge clk_i);
        rst_i = chance(ph.p_rst);
        for (int n = 0; n < 3; n++) begin
            logic [31:0] a;
            logic [1:0]  other;
            a = $urandom;
            req_valid[n] = ph.mask[n] && chance(ph.p_valid);
            req_op[n]    = 2'($urandom_range(3));
            req_addr[n]  = a[31:4];
            other        = BANK + 2'($urandom_range(1, 3));
            req_addr[n][5:4] = chance(ph.p_bank) ? BANK : other;
            rtn_done[n]  = !no_done && chance(ph.p_done);
        end
        htu_allow = chance(ph.p_allow);
        #1;
        load  = !m_valid || htu_allow;
        grant = -1;
        for (int n = 0; n < 3; n++)
            hit[n] = req_valid[n] && (req_addr[n][5:4] == BANK) && (m_outst[n] < 8);
        if (!rst_i && load) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (grant < 0 && hit[c]) grant = c;
            end
        end
        check("htu_valid", htu_valid, m_valid);
        for (int n = 0; n < 3; n++)
            check($sformatf("allowIn_ch%0d", n), allow_vec[n], grant == n);
        if (rst_i) begin
            model_reset();
        end else begin
            for (int n = 0; n < 3; n++) begin
                bit inc, dec;
                inc = (grant == n);
                dec = rtn_done[n] && m_outst[n] > 0;
                m_outst[n] += int'(inc) - int'(dec);
            end
            if (grant >= 0) begin
                exp_t e;
                e.ch   = grant;
                e.op   = req_op[grant];
                e.addr = req_addr[grant];
                e.rob  = m_rob[grant];
                sb.push_back(e);
                m_rob[grant] = (m_rob[grant] + 1) % 8;
                m_last  = grant;
                m_valid = 1;
            end else if (htu_allow) begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        //            cyc  val bank allow done rst  mask
        phases[0] = '{ 12, 100, 100, 100,  0,  0, 3'b111};  // contested, ordered grants
        phases[1] = '{ 30, 100,   0, 100, 40,  0, 3'b111};  // wrong bank only
        phases[2] = '{ 60,  90,  90,  10, 30,  0, 3'b111};  // long stalls
        phases[3] = '{ 40, 100, 100, 100,  0,  0, 3'b100};  // ch2 saturates at 8
        phases[4] = '{ 40, 100, 100, 100, 30,  0, 3'b100};  // ch2 retires
        phases[5] = '{600,  70,  70,  60, 30,  0, 3'b111};  // mixed random
        phases[6] = '{600,  80,  80,  70, 20,  3, 3'b111};  // random with resets
        phases[7] = '{ 20,   0,   0, 100, 50,  0, 3'b111};  // drain

        rst_i     = 1'b1;
        req_valid = '0;
        rtn_done  = '0;
        htu_allow = 1'b0;
        for (int n = 0; n < 3; n++) begin
            req_op[n]   = '0;
            req_addr[n] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_valid", htu_valid, 0);
        check("reset_fields", {htu_ch_id, htu_opcode, htu_addr, htu_rob}, 0);
        check("reset_allow", allow_vec, 0);
        rst_i = 1'b0;

        for (int p = 0; p < 8; p++)
            for (int c = 0; c < phases[p].cycles; c++)
                run_cycle(phases[p], 1'b0);

        @(negedge clk_i);
        #3;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/xbar_bank_arb.md
XBAR_BANK_ARB -- requirements
Module: xbar_bank_arb

Interface
REQ-001 SHALL have parameter BANK_ID, default 0, 2-bit: the bank this instance serves, selected by request addr[5:4].
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports chN_req_valid_i (N=0..2), input, 1: channel N request valid.
REQ-005 SHALL have ports chN_req_allowIn_o, output, 1: channel N request accepted by this bank this cycle.
REQ-006 SHALL have ports chN_req_op_i, input, 2: channel N opcode.
REQ-007 SHALL have ports chN_req_addr_i, input, [31:4]: channel N line address.
REQ-008 SHALL have ports chN_rtn_done_i, input, 1: pulse that retires one outstanding channel-N request for this bank.
REQ-009 SHALL have port bank_htu_valid_o, output, 1: output stage holds a request.
REQ-010 SHALL have port bank_htu_allowIn_i, input, 1: bank HTU accepts the output this cycle.
REQ-011 SHALL have port bank_htu_ch_id_o, output, 2: source channel of the output request.
REQ-012 SHALL have port bank_htu_opcode_o, output, 2: opcode of the output request.
REQ-013 SHALL have port bank_htu_addr_o, output, [31:4]: address of the output request.
REQ-014 SHALL have port bank_htu_rob_num_o, output, 3: per-channel ROB tag of the output request.

Function
REQ-015 SHALL define hit_N = chN_req_valid_i & (chN_req_addr_i[5:4] == BANK_ID) & (outstanding_N < 8).
REQ-016 SHALL define load = ~bank_htu_valid_o | bank_htu_allowIn_i (single-entry output register; bubble-free back-to-back).
REQ-017 SHALL grant at most one channel per cycle, only when load=1 and some hit_N=1.
REQ-018 SHALL arbitrate round-robin: search order starts at (last_grant+1) mod 3, wraps 2->0; last_grant updates only on a grant.
REQ-019 SHALL drive chN_req_allowIn_o = 1 exactly in the cycle channel N is granted; combinational, no dependence on itself.
REQ-020 SHALL, on grant of N, load ch_id=N, opcode, addr, rob_num=rob_ptr_N into the output register next cycle and set bank_htu_valid_o=1.
REQ-021 SHALL clear bank_htu_valid_o when bank_htu_allowIn_i=1 and no grant occurs that cycle.
REQ-022 SHALL hold all output fields stable while bank_htu_valid_o=1 and bank_htu_allowIn_i=0.
REQ-023 SHALL keep per-channel 3-bit rob_ptr_N, incremented mod 8 (7->0 wrap) on each grant of N.
REQ-024 SHALL keep per-channel 4-bit outstanding_N (range 0..8): +1 on grant of N, -1 on chN_rtn_done_i, unchanged when both occur in the same cycle.
REQ-025 SHALL ignore chN_rtn_done_i when outstanding_N=0 (no underflow); grant is impossible at 8 (no overflow).
REQ-026 SHALL give fixed latency of 1 cycle from grant (allowIn_o high) to bank_htu_valid_o high.
REQ-027 SHALL not use bank_htu_allowIn_i to alter the output fields in a cycle where bank_htu_valid_o=0.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, clear bank_htu_valid_o, all output fields, rob_ptr_N, outstanding_N to 0 and set last_grant=2 (channel 0 first priority).
REQ-029 SHALL, on reset mid-operation, discard any held output request and ignore rtn_done pulses in that cycle; chN_req_allowIn_o SHALL be 0 during reset.

Verification
REQ-030 SHALL verify: BANK_ID=1, ch0/ch1/ch2 all valid with addr[5:4]=1, allowIn_i=1 for 3 cycles -> grants ch0, ch1, ch2 in order, ch_id_o 0,1,2 one cycle later, rob_num_o 0 each.
REQ-031 SHALL verify: ch1 valid, addr[5:4]=2 with BANK_ID=1 -> ch1_req_allowIn_o=0, bank_htu_valid_o stays 0.
REQ-032 SHALL verify: output valid, allowIn_i=0 for 4 cycles with ch0 pending -> fields constant, ch0_req_allowIn_o=0; allowIn_i=1 -> ch0 granted same cycle, new entry next cycle with no bubble.
REQ-033 SHALL verify: 8 ch2 grants with no rtn_done -> rob_num_o 0..7, ninth request blocked (allowIn_o=0); one ch2_rtn_done_i -> ninth granted with rob_num_o=0.
REQ-034 SHALL verify: grant of ch0 and ch0_rtn_done_i in same cycle with outstanding_0=3 -> outstanding_0 stays 3; rtn_done at outstanding 0 -> stays 0.
REQ-035 SHALL verify: rst_i=1 while bank_htu_valid_o=1 and outstanding_1=5 -> next cycle valid=0, counters 0, first subsequent contested grant goes to ch0.
